// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register address width, pipeline-controller
// FSM states and the load-use hazard predicate.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {RUN, MDU_WAIT} pctl_state_t;

    // True when the load in EX writes a register that the ID instruction reads
    function automatic logic load_use_hit(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  uses_rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  uses_rs2
    );
        return mem_read && (rd != '0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs, stage controls and performance counters of the pipeline controller.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import riscv_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  ex_mdu_start;
    logic                  dmem_busy;

    logic                  pc_we;
    logic                  if_id_we;
    logic                  if_id_flush;
    logic                  id_ex_we;
    logic                  id_ex_flush;
    logic                  ex_mem_we;
    logic                  ex_mem_flush;
    logic                  mdu_busy;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // Datapath side: reports hazards, consumes stage controls
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_start, dmem_busy,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mdu_busy, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_start, dmem_busy,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mdu_busy, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_cnt.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: freeze, MDU stall, branch redirect and load-use
// handling with combinational stage controls and saturating perf counters.
module pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    localparam int unsigned MCNT_W    = $clog2(MUL_LAT) + 1;
    localparam bit          MDU_EN    = (MUL_LAT > 1);
    localparam int unsigned MCNT_INIT = MDU_EN ? (MUL_LAT - 2) : 0;

    pctl_state_t       state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;

    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush;
    logic flush_ev;
    logic load_use;
    logic mdu_stall;
    logic mdu_last;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign load_use  = load_use_hit(bus.ex_mem_read, bus.ex_rd, bus.id_rs1,
                                    bus.id_uses_rs1, bus.id_rs2, bus.id_uses_rs2);
    assign mdu_stall = (state_q == MDU_WAIT) ||
                       ((state_q == RUN) && bus.ex_mdu_start && MDU_EN);
    assign mdu_last  = (state_q == MDU_WAIT) && (mcnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b1;
        ex_mem_flush = 1'b0;
        flush_ev     = 1'b0;

        if (bus.dmem_busy) begin
            // Freeze: every stage holds, FSM and mcnt included
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else begin
            if (state_q == RUN) begin
                if (bus.ex_mdu_start && MDU_EN) begin
                    state_d = MDU_WAIT;
                    mcnt_d  = MCNT_W'(MCNT_INIT);
                end
            end else if (mcnt_q == '0) begin
                state_d = RUN;
            end else begin
                mcnt_d = mcnt_q - MCNT_W'(1);
            end

            // Final MDU cycle lets the result into EX/MEM instead of a bubble
            if (mdu_stall) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_we     = 1'b0;
                ex_mem_flush = !mdu_last;
            end else if (bus.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_ev    = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (!pc_we),
        .count_o (stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (flush_ev),
        .count_o (flush_cnt)
    );

    assign bus.pc_we        = pc_we;
    assign bus.if_id_we     = if_id_we;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_we     = id_ex_we;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_we    = ex_mem_we;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mdu_busy     = (state_q == MDU_WAIT);
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance A (MUL_LAT=4, CNT_W=4) and
// instance B (MUL_LAT=1, CNT_W=16) see identical stimulus.
module tb_pipe_ctrl;
    import riscv_pkg::*;

    // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush}
    localparam logic [6:0] C_RUN    = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_MDU    = 7'b0000011;
    localparam logic [6:0] C_MLAST  = 7'b0000010;
    localparam logic [6:0] C_BR     = 7'b1111110;
    localparam logic [6:0] C_LU     = 7'b0001110;

    logic clk;
    logic rst_n;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mdu_start, dmem_busy;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_if #(.CNT_W(4))  if_a ();
    pipe_ctrl_if #(.CNT_W(16)) if_b ();

    assign if_a.id_rs1 = id_rs1;           assign if_b.id_rs1 = id_rs1;
    assign if_a.id_rs2 = id_rs2;           assign if_b.id_rs2 = id_rs2;
    assign if_a.id_uses_rs1 = id_uses_rs1; assign if_b.id_uses_rs1 = id_uses_rs1;
    assign if_a.id_uses_rs2 = id_uses_rs2; assign if_b.id_uses_rs2 = id_uses_rs2;
    assign if_a.ex_rd = ex_rd;             assign if_b.ex_rd = ex_rd;
    assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
    assign if_a.ex_branch_taken = ex_branch_taken;
    assign if_b.ex_branch_taken = ex_branch_taken;
    assign if_a.ex_mdu_start = ex_mdu_start;
    assign if_b.ex_mdu_start = ex_mdu_start;
    assign if_a.dmem_busy = dmem_busy;     assign if_b.dmem_busy = dmem_busy;

    pipe_ctrl #(.MUL_LAT(4), .CNT_W(4))  u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    pipe_ctrl #(.MUL_LAT(1), .CNT_W(16)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    logic [6:0]  ctl_a, ctl_b;
    logic [15:0] obs;
    logic [39:0] cnts;
    logic [15:0] exp_obs;

    assign ctl_a = {if_a.pc_we, if_a.if_id_we, if_a.if_id_flush, if_a.id_ex_we,
                    if_a.id_ex_flush, if_a.ex_mem_we, if_a.ex_mem_flush};
    assign ctl_b = {if_b.pc_we, if_b.if_id_we, if_b.if_id_flush, if_b.id_ex_we,
                    if_b.id_ex_flush, if_b.ex_mem_we, if_b.ex_mem_flush};
    assign obs   = {ctl_a, if_a.mdu_busy, ctl_b, if_b.mdu_busy};
    assign cnts  = {if_a.stall_cnt, if_a.flush_cnt, if_b.stall_cnt, if_b.flush_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0}) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", obs, {C_RUN, 1'b0, C_RUN, 1'b0});
        end
        checks++;
        if (cnts !== 40'd0) begin
            errors++; $display("FAIL reset_cnt: got %h want 0", cnts);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (obs !== {C_LU, 1'b0, C_LU, 1'b0}) begin
            errors++; $display("FAIL lu_rs1: got %b want %b", obs, {C_LU, 1'b0, C_LU, 1'b0});
        end
        step();
        idle();
        #1;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0} || cnts !== {4'd1, 4'd0, 16'd1, 16'd0}) begin
            errors++; $display("FAIL lu_bubble: got %b/%h want %b/%h", obs, cnts,
                               {C_RUN, 1'b0, C_RUN, 1'b0}, {4'd1, 4'd0, 16'd1, 16'd0});
        end
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0}) begin
            errors++; $display("FAIL lu_x0: got %b want %b", obs, {C_RUN, 1'b0, C_RUN, 1'b0});
        end
        step();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (obs !== {C_LU, 1'b0, C_LU, 1'b0}) begin
            errors++; $display("FAIL lu_rs2: got %b want %b", obs, {C_LU, 1'b0, C_LU, 1'b0});
        end
        id_uses_rs2 = 1'b0;
        #1;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0}) begin
            errors++; $display("FAIL lu_unused: got %b want %b", obs, {C_RUN, 1'b0, C_RUN, 1'b0});
        end
        step();
        idle();
        #1;
        checks++;
        if (cnts !== {4'd1, 4'd0, 16'd1, 16'd0}) begin
            errors++; $display("FAIL lu_count: got %h want %h", cnts, {4'd1, 4'd0, 16'd1, 16'd0});
        end
    endtask

    task automatic test_branch();
        do_reset();
        step();
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (obs !== {C_BR, 1'b0, C_BR, 1'b0}) begin
            errors++; $display("FAIL br_ctl: got %b want %b", obs, {C_BR, 1'b0, C_BR, 1'b0});
        end
        step();
        idle();
        #1;
        checks++;
        if (cnts !== {4'd0, 4'd1, 16'd0, 16'd1}) begin
            errors++; $display("FAIL br_count: got %h want %h", cnts, {4'd0, 4'd1, 16'd0, 16'd1});
        end
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (obs !== {C_BR, 1'b0, C_BR, 1'b0}) begin
            errors++; $display("FAIL br_lu_ctl: got %b want %b", obs, {C_BR, 1'b0, C_BR, 1'b0});
        end
        step();
        idle();
        #1;
        checks++;
        if (cnts !== {4'd0, 4'd2, 16'd0, 16'd2}) begin
            errors++; $display("FAIL br_lu_count: got %h want %h", cnts, {4'd0, 4'd2, 16'd0, 16'd2});
        end
    endtask

    task automatic test_mdu();
        do_reset();
        step();
        ex_mdu_start = 1'b1;
        #1;
        checks++;
        if (obs !== {C_MDU, 1'b0, C_RUN, 1'b0}) begin
            errors++; $display("FAIL mdu_issue: got %b want %b", obs, {C_MDU, 1'b0, C_RUN, 1'b0});
        end
        // EX holds the MUL during the wait, so ex_mdu_start stays high and must be ignored
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            exp_obs = {(i < 2) ? C_MDU : C_MLAST, 1'b1, C_RUN, 1'b0};
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL mdu_wait%0d: got %b want %b", i, obs, exp_obs);
            end
        end
        step();
        idle();
        #1;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0} || cnts !== {4'd4, 4'd0, 16'd0, 16'd0}) begin
            errors++; $display("FAIL mdu_done: got %b/%h want %b/%h", obs, cnts,
                               {C_RUN, 1'b0, C_RUN, 1'b0}, {4'd4, 4'd0, 16'd0, 16'd0});
        end
    endtask

    task automatic test_freeze_mdu();
        logic [6:0] seq_a [6];
        logic       seq_busy [6];
        logic       seq_frz [6];
        seq_a    = '{C_MDU, C_MDU, C_FREEZE, C_FREEZE, C_MDU, C_MLAST};
        seq_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        seq_frz  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            ex_mdu_start = (i == 0);
            dmem_busy    = seq_frz[i];
            #1;
            exp_obs = {seq_a[i], seq_busy[i], seq_frz[i] ? C_FREEZE : C_RUN, 1'b0};
            checks++;
            if (obs !== exp_obs) begin
                errors++; $display("FAIL frz_mdu%0d: got %b want %b", i, obs, exp_obs);
            end
        end
        step();
        idle();
        #1;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0} || cnts !== {4'd6, 4'd0, 16'd2, 16'd0}) begin
            errors++; $display("FAIL frz_done: got %b/%h want %b/%h", obs, cnts,
                               {C_RUN, 1'b0, C_RUN, 1'b0}, {4'd6, 4'd0, 16'd2, 16'd0});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        repeat (20) step();
        idle();
        #1;
        checks++;
        if (cnts !== {4'd15, 4'd0, 16'd20, 16'd0}) begin
            errors++; $display("FAIL sat_stall: got %h want %h", cnts, {4'd15, 4'd0, 16'd20, 16'd0});
        end
    endtask

    task automatic test_reset_mdu();
        do_reset();
        step();
        ex_branch_taken = 1'b1;
        step();
        ex_branch_taken = 1'b0;
        ex_mdu_start = 1'b1;
        step();
        ex_mdu_start = 1'b0;
        #1;
        checks++;
        if (if_a.mdu_busy !== 1'b1 || cnts !== {4'd1, 4'd1, 16'd0, 16'd1}) begin
            errors++; $display("FAIL rst_pre: got %b/%h want 1/%h", if_a.mdu_busy, cnts,
                               {4'd1, 4'd1, 16'd0, 16'd1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {C_RUN, 1'b0, C_RUN, 1'b0} || cnts !== 40'd0) begin
            errors++; $display("FAIL rst_async: got %b/%h want %b/0", obs, cnts,
                               {C_RUN, 1'b0, C_RUN, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_freeze_mdu();
        test_saturation();
        test_reset_mdu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
